// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - instruction-memory request/response interface for the fetch stage
interface if_fetch_queue_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch queue feeding the IF/ID pipeline register
module if_fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             pc_i,
   input  logic                    ce_i,
   input  logic [5:0]              stall,
   input  logic                    flush,
   if_fetch_queue_if.master        imem,
   output logic                    stallreq_if,
   output logic [31:0]             id_pc,
   output logic [31:0]             id_inst,
   output logic                    id_valid
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   // Extra headroom: drops owed can exceed DEPTH across back-to-back flushes.
   localparam int DW = PW + 4;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [DW-1:0] cnt_t;

   ptr_t              wr_ptr_q, wr_ptr_d;
   ptr_t              fill_ptr_q, fill_ptr_d;
   ptr_t              rd_ptr_q, rd_ptr_d;
   cnt_t              drop_cnt_q, drop_cnt_d;
   logic              issued_q, issued_d;
   logic [31:0]       pc_mem_q [DEPTH];
   logic [31:0]       pc_mem_d [DEPTH];
   logic [31:0]       inst_mem_q [DEPTH];
   logic [31:0]       inst_mem_d [DEPTH];
   logic [DEPTH-1:0]  filled_q, filled_d;
   logic [31:0]       id_pc_q, id_pc_d;
   logic [31:0]       id_inst_q, id_inst_d;
   logic              id_valid_q, id_valid_d;

   ptr_t              alloc;
   ptr_t              owed;
   logic              grant;
   logic              drop_rsp;
   logic              fill_we;
   logic [AW-1:0]     head;
   logic              head_bypass;
   logic              head_ready;
   logic [31:0]       head_inst;
   logic              unused_stall_hi;

   assign unused_stall_hi = ^stall[5:2];

   assign alloc = wr_ptr_q - rd_ptr_q;
   assign owed  = wr_ptr_q - fill_ptr_q;

   // Request path never looks at stall, so the controller's stall[0] cannot loop back into it.
   assign imem.imem_req  = ce_i & ~flush & ~issued_q & (alloc < ptr_t'(DEPTH));
   assign imem.imem_addr = pc_i;
   assign grant          = imem.imem_req & imem.imem_gnt;
   assign stallreq_if    = ce_i & ~issued_q & ~grant;

   assign drop_rsp = imem.imem_rvalid & (drop_cnt_q != '0);
   assign fill_we  = imem.imem_rvalid & (drop_cnt_q == '0) & (fill_ptr_q != wr_ptr_q);

   // The head can be consumed in the same cycle its response arrives, giving 2-cycle grant-to-ID.
   assign head        = rd_ptr_q[AW-1:0];
   assign head_bypass = fill_we & (fill_ptr_q == rd_ptr_q);
   assign head_ready  = (rd_ptr_q != wr_ptr_q) & (filled_q[head] | head_bypass);
   assign head_inst   = filled_q[head] ? inst_mem_q[head] : imem.imem_rdata;

   assign id_pc    = id_pc_q;
   assign id_inst  = id_inst_q;
   assign id_valid = id_valid_q;

   // Next-state for pointers, queue storage, drop counter, issue flag and IF/ID register.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      fill_ptr_d = fill_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      drop_cnt_d = drop_cnt_q;
      issued_d   = issued_q;
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;
      filled_d   = filled_q;
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;

      if (flush) begin
         fill_ptr_d = wr_ptr_q;
         rd_ptr_d   = wr_ptr_q;
         filled_d   = '0;
         // Every response still owed for pre-flush grants, net of one arriving this cycle.
         drop_cnt_d = cnt_t'(owed) - cnt_t'(fill_we) + drop_cnt_q - cnt_t'(drop_rsp);
         issued_d   = 1'b0;
         id_valid_d = 1'b0;
         id_inst_d  = '0;
      end else begin
         if (grant) begin
            pc_mem_d[wr_ptr_q[AW-1:0]] = pc_i;
            filled_d[wr_ptr_q[AW-1:0]] = 1'b0;
            wr_ptr_d                   = wr_ptr_q + ptr_t'(1);
         end

         if (drop_rsp) begin
            drop_cnt_d = drop_cnt_q - cnt_t'(1);
         end

         if (fill_we) begin
            inst_mem_d[fill_ptr_q[AW-1:0]] = imem.imem_rdata;
            filled_d[fill_ptr_q[AW-1:0]]   = 1'b1;
            fill_ptr_d                     = fill_ptr_q + ptr_t'(1);
         end

         // A grant while the PC is held must not be re-requested until the PC moves.
         if (!stall[0]) begin
            issued_d = 1'b0;
         end else if (grant) begin
            issued_d = 1'b1;
         end

         if (!stall[1]) begin
            if (head_ready) begin
               id_pc_d    = pc_mem_q[head];
               id_inst_d  = head_inst;
               id_valid_d = 1'b1;
               rd_ptr_d   = rd_ptr_q + ptr_t'(1);
            end else begin
               id_inst_d  = '0;
               id_valid_d = 1'b0;
            end
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         fill_ptr_q <= '0;
         rd_ptr_q   <= '0;
         drop_cnt_q <= '0;
         issued_q   <= 1'b0;
         pc_mem_q   <= '{default: '0};
         inst_mem_q <= '{default: '0};
         filled_q   <= '0;
         id_pc_q    <= '0;
         id_inst_q  <= '0;
         id_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         fill_ptr_q <= fill_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         drop_cnt_q <= drop_cnt_d;
         issued_q   <= issued_d;
         pc_mem_q   <= pc_mem_d;
         inst_mem_q <= inst_mem_d;
         filled_q   <= filled_d;
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
         id_valid_q <= id_valid_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed self-checking bench for if_fetch_queue
module tb_if_fetch_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        ce;
   logic        flush;
   logic        hold0;
   logic        hold1;
   logic [5:0]  stall;
   logic        stallreq_if;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;

   logic        gnt_en;
   logic        rv_en;
   logic [31:0] pend[$];
   logic [31:0] got[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          n_gnt = 0;

   logic        c_req;
   logic        c_srq;
   logic        c_s0;
   logic        c_h1;
   logic        c_rv;
   logic [31:0] c_addr;

   if_fetch_queue_if mif ();

   if_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_i        (pc),
      .ce_i        (ce),
      .stall       (stall),
      .flush       (flush),
      .imem        (mif),
      .stallreq_if (stallreq_if),
      .id_pc       (id_pc),
      .id_inst     (id_inst),
      .id_valid    (id_valid)
   );

   always #5 clk = ~clk;

   // Stall controller: ORs the fetch stall request into the PC hold bit.
   assign stall = {4'b0000, hold1, stallreq_if | hold0};

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return (a * 32'd3) ^ 32'h0BAD_0001;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // One clock: drive inputs, sample combinational outputs at negedge, then update memory/PC model.
   task automatic step();
      mif.imem_gnt    = gnt_en;
      mif.imem_rvalid = rv_en && (pend.size() > 0);
      mif.imem_rdata  = (rv_en && (pend.size() > 0)) ? inst_of(pend[0]) : 32'h0;
      @(negedge clk);
      c_req  = mif.imem_req;
      c_srq  = stallreq_if;
      c_addr = mif.imem_addr;
      c_s0   = stall[0];
      c_h1   = hold1;
      c_rv   = mif.imem_rvalid;
      @(posedge clk);
      #1;
      if (!rst) begin
         pend.delete();
      end else begin
         if (c_rv) void'(pend.pop_front());
         if (c_req && gnt_en) begin
            pend.push_back(c_addr);
            n_gnt++;
         end
         if (ce && !flush && !c_s0) pc = pc + 32'd4;
         if (id_valid && !c_h1) begin
            got.push_back(id_pc);
            check_eq("id_inst", id_inst, inst_of(id_pc));
         end
      end
   endtask

   task automatic drain(input int n);
      ce = 1'b0;
      rv_en = 1'b1;
      repeat (n) step();
   endtask

   initial begin
      rst = 1'b0; pc = 32'h0; ce = 1'b0; flush = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
      gnt_en = 1'b0; rv_en = 1'b0;
      mif.imem_gnt = 1'b0; mif.imem_rvalid = 1'b0; mif.imem_rdata = 32'h0;

      // Reset state
      step();
      check_eq("rst_idv", id_valid, 0);
      check_eq("rst_idpc", id_pc, 0);
      check_eq("rst_idinst", id_inst, 0);
      check_eq("rst_req", c_req, 0);
      #3 rst = 1'b1;

      // Zero-wait memory: one instruction per cycle after 2-cycle fill
      got.delete(); pc = 32'h0; ce = 1'b1; gnt_en = 1'b1; rv_en = 1'b1;
      step();
      check_eq("t1_req0", c_req, 1);
      check_eq("t1_addr0", c_addr, 32'h0);
      check_eq("t1_srq0", c_srq, 0);
      check_eq("t1_idv0", id_valid, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("t1_srq", c_srq, 0);
         check_eq("t1_idv", id_valid, 1);
         check_eq("t1_idpc", id_pc, 32'(4 * k));
      end
      drain(4);

      // Grant withheld 3 cycles at 0x10
      got.delete(); n_gnt = 0; pc = 32'h10; ce = 1'b1; gnt_en = 1'b0;
      repeat (3) begin
         step();
         check_eq("t2_srq_wait", c_srq, 1);
         check_eq("t2_req_wait", c_req, 1);
      end
      gnt_en = 1'b1;
      step();
      check_eq("t2_srq_gnt", c_srq, 0);
      check_eq("t2_addr_gnt", c_addr, 32'h10);
      drain(3);
      check_eq("t2_ngnt", n_gnt, 1);
      check_eq("t2_nid", got.size(), 1);
      if (got.size() > 0) check_eq("t2_id0", got[0], 32'h10);

      // IF/ID held 6 cycles: queue fills to DEPTH, then releases in order
      got.delete(); n_gnt = 0; pc = 32'h40; ce = 1'b1; gnt_en = 1'b1; rv_en = 1'b1; hold1 = 1'b1;
      repeat (4) begin
         step();
         check_eq("t3_req_fill", c_req, 1);
      end
      repeat (2) begin
         step();
         check_eq("t3_req_full", c_req, 0);
         check_eq("t3_srq_full", c_srq, 1);
         check_eq("t3_idv_hold", id_valid, 0);
      end
      check_eq("t3_ngnt", n_gnt, 4);
      hold1 = 1'b0;
      drain(5);
      check_eq("t3_nid", got.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < got.size()) check_eq("t3_order", got[i], 32'h40 + 32'(4 * i));

      // Flush with two requests outstanding: stale responses dropped
      got.delete(); pc = 32'h20; ce = 1'b1; gnt_en = 1'b1; rv_en = 1'b0;
      step();
      step();
      flush = 1'b1;
      step();
      check_eq("t4_req_flush", c_req, 0);
      check_eq("t4_idv_flush", id_valid, 0);
      check_eq("t4_drop", dut.drop_cnt_q, 2);
      flush = 1'b0; pc = 32'h100; rv_en = 1'b1;
      repeat (3) step();
      check_eq("t4_idv_new", id_valid, 1);
      check_eq("t4_idpc_new", id_pc, 32'h100);
      drain(3);
      check_eq("t4_nid", got.size(), 3);
      if (got.size() > 0) check_eq("t4_first", got[0], 32'h100);

      // Flush coincident with a response and a grant
      got.delete(); pc = 32'h200; ce = 1'b1; gnt_en = 1'b1; rv_en = 1'b0;
      repeat (3) step();
      flush = 1'b1; rv_en = 1'b1;
      step();
      check_eq("t5_req_flush", c_req, 0);
      check_eq("t5_drop", dut.drop_cnt_q, 2);
      flush = 1'b0; pc = 32'h300; rv_en = 1'b0;
      step();
      check_eq("t5_drop_hold", dut.drop_cnt_q, 2);
      drain(4);
      check_eq("t5_drop_end", dut.drop_cnt_q, 0);
      check_eq("t5_nid", got.size(), 1);
      if (got.size() > 0) check_eq("t5_first", got[0], 32'h300);

      // External PC hold during a grant: no duplicate request
      got.delete(); pc = 32'h600; ce = 1'b1; gnt_en = 1'b1; rv_en = 1'b1; hold0 = 1'b1;
      step();
      check_eq("t6_req0", c_req, 1);
      check_eq("t6_srq0", c_srq, 0);
      step();
      check_eq("t6_req_issued", c_req, 0);
      check_eq("t6_srq_issued", c_srq, 0);
      hold0 = 1'b0;
      step();
      check_eq("t6_req_clear", c_req, 0);
      step();
      check_eq("t6_req_next", c_req, 1);
      check_eq("t6_addr_next", c_addr, 32'h604);
      drain(3);
      check_eq("t6_nid", got.size(), 2);
      if (got.size() > 1) check_eq("t6_id1", got[1], 32'h604);

      // Asynchronous reset mid-stream, then restart at a new PC
      got.delete(); pc = 32'h400; ce = 1'b1; gnt_en = 1'b1; rv_en = 1'b1;
      repeat (3) step();
      check_eq("t7_idv_pre", id_valid, 1);
      #2 rst = 1'b0;
      #1;
      check_eq("t7_idv_async", id_valid, 0);
      check_eq("t7_idpc_async", id_pc, 0);
      check_eq("t7_idinst_async", id_inst, 0);
      step();
      #3 rst = 1'b1;
      pc = 32'h500; got.delete();
      step();
      step();
      check_eq("t7_idv_restart", id_valid, 1);
      check_eq("t7_idpc_restart", id_pc, 32'h500);
      drain(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction-fetch stage between the `pc` register and the ID stage of the 5-stage MIPS pipeline. Issues one instruction-memory request per PC value, tracks in-flight requests, and buffers returned instructions in an in-order queue. Drives the IF/ID pipeline register to ID. Asks the stall controller to hold the PC while a request cannot be issued, and discards stale responses after a flush.

## Interface
- `DEPTH`, 4: queue entries and maximum requests outstanding; power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc_i`  in  32  current PC from the pc stage.
- `ce_i`  in  1  PC valid (pc stage chip-enable).
- `stall`  in  6  pipeline stall vector; bit 0 = PC hold, bit 1 = IF/ID hold.
- `flush`  in  1  pipeline flush; highest priority.
- `imem_req`  out  1  request valid (combinational).
- `imem_addr`  out  32  request address, equal to `pc_i`.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; responses return in order, at least 1 cycle after grant.
- `imem_rdata`  in  32  response instruction.
- `stallreq_if`  out  1  stall request to the controller, which ORs it into `stall[0]` (combinational).
- `id_pc`  out  32  IF/ID PC.
- `id_inst`  out  32  IF/ID instruction.
- `id_valid`  out  1  IF/ID entry valid.

## Operation
- Queue state:
  - Each entry holds {pc, inst, filled}.
  - Pointers: `wr_ptr` (allocate), `fill_ptr` (response), `rd_ptr` (consume); each is log2(DEPTH)+1 bits and wraps naturally.
  - `alloc = wr_ptr - rd_ptr`, in the range 0..DEPTH.
- Issue:
  - `imem_req = ce_i & ~flush & ~issued & (alloc < DEPTH)`.
  - On `imem_req & imem_gnt`: write `pc_i` at `wr_ptr`, clear `filled`, increment `wr_ptr`.
- `issued` flag prevents re-requesting a held PC:
  - Set on a grant cycle where `stall[0]=1`.
  - Cleared on any cycle with `stall[0]=0`, or on `flush`.
- `stallreq_if = ce_i & ~issued & ~(imem_req & imem_gnt)`.
- Response (`imem_rvalid=1`):
  - If `drop_cnt>0`: discard the response and decrement `drop_cnt`.
  - Else, if `fill_ptr != wr_ptr`: write `imem_rdata` at `fill_ptr`, set `filled`, increment `fill_ptr`.
  - Else: protocol violation; ignore.
- IF/ID register, when `stall[1]=0`:
  - If the head entry is filled: load {pc, inst}, set `id_valid=1`, increment `rd_ptr`.
  - Otherwise: load a bubble (`id_valid=0`, `id_inst=0`, `id_pc` unchanged).
  - When `stall[1]=1`, the register holds and nothing is consumed.
- Flush (overrides all of the above in that cycle):
  - All pointers := `wr_ptr`; every queued entry is invalidated.
  - `drop_cnt := (wr_ptr - fill_ptr) - (imem_rvalid & drop_cnt==0 ? 1 : 0) + (drop_cnt - (imem_rvalid & drop_cnt>0 ? 1 : 0))`, i.e. every response still owed for pre-flush grants.
  - `id_valid := 0`, `id_inst := 0`; `issued := 0`.
  - No request is issued during the flush cycle.
- Simultaneous grant and response in one cycle: both are processed; pointers are independent.
- The queue is full when `alloc==DEPTH`: `imem_req=0` and `stallreq_if=1` while `ce_i`.

## Timing
- Reset (async assert, release on the clock):
  - `id_pc=0`, `id_inst=0`, `id_valid=0`.
  - Pointers 0, `drop_cnt=0`, `issued=0`.
  - `imem_req=0` while `ce_i=0`.
- Latency: grant at cycle t with response at t+1 → `id_valid=1` visible from cycle t+2 (2-cycle minimum, grant to ID).
- Throughput: with single-cycle grant and rvalid, one instruction per cycle after a 2-cycle fill.
- `stallreq_if` and `imem_req` are combinational from `imem_gnt`, `ce_i`, `flush`, and state. There is no path from `stall` into `imem_req` in the same cycle.
- Reset mid-operation discards all queued and in-flight state. The memory side is reset by the same `rst`.

## Test plan
- Zero-wait memory (gnt always 1, rvalid one cycle later), PCs 0x0, 0x4, 0x8 → `id_pc` = 0x0, 0x4, 0x8 on cycles 2, 3, 4 with matching `id_inst`; `stallreq_if=0` throughout.
- Grant withheld for 3 cycles at PC 0x10 → `stallreq_if=1` for 3 cycles, exactly one grant for 0x10, no duplicate entry.
- `stall[1]=1` held for 6 cycles with DEPTH=4 → four grants, then `imem_req=0` and `stallreq_if=1`; on release, ID receives the four PCs in order with no loss.
- Two requests outstanding (0x20, 0x24); flush with `new_pc`=0x100 → the two old responses are dropped; the first `id_valid` carries `id_pc=0x100`.
- Flush coincident with an rvalid and a grant → the grant is suppressed, the rvalid is counted as dropped, `drop_cnt` equals the remaining old outstanding count.
- Assert `rst=0` mid-stream, asynchronously between clock edges → outputs are 0 immediately; after release, fetch restarts at the PC presented.
